// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main controller for a multicycle MIPS datapath. A Moore FSM walks each
//   instruction through fetch, decode, execute, memory and writeback, and
//   stalls in the memory states until MemReady is seen.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; returns the FSM to FETCH
//   opcode[5:0]  IR opcode field, sampled in DECODE
//   MemReady     memory finishes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemToReg, RegDest, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0],
//   PCSource[1:0]  datapath enables and mux selects
//   Illegal      one-cycle pulse after an undefined opcode is decoded
//   State[3:0]   current FSM state, for debug
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE    = 6'h00,
  parameter logic [5:0] OP_LW       = 6'h23,
  parameter logic [5:0] OP_SW       = 6'h2B,
  parameter logic [5:0] OP_BEQ      = 6'h04,
  parameter logic [5:0] OP_J        = 6'h02,
  parameter logic [5:0] OP_ADDI     = 6'h08,
  parameter bit         ENABLE_JUMP = 1'b1,
  parameter bit         ENABLE_ADDI = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDest,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   is_lw_q, is_lw_d;     // lw vs sw, captured in DECODE
  logic   illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    is_lw_d   = is_lw_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        is_lw_d = (opcode == OP_LW);
        if (opcode == OP_LW || opcode == OP_SW)   state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)               state_d = S_EXEC;
        else if (opcode == OP_BEQ)                 state_d = S_BRANCH;
        else if (ENABLE_JUMP && opcode == OP_J)    state_d = S_JUMP;
        else if (ENABLE_ADDI && opcode == OP_ADDI) state_d = S_ADDIEX;
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH; // writeback/branch/jump and unused codes
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      is_lw_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_lw_q   <= is_lw_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode; the FETCH load strobes are additionally qualified by
  // MemReady, and reset masks every write/request strobe immediately.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDest     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign Illegal = illegal_q;
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. A second instance built with
//   ENABLE_JUMP=0 runs on the same inputs to cover the disabled-jump case.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       MemReady;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDest, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  logic       PCWrite_nj, PCWriteCond_nj, IorD_nj, MemRead_nj, MemWrite_nj;
  logic       IRWrite_nj, MemToReg_nj, RegDest_nj, RegWrite_nj, ALUSrcA_nj;
  logic       Illegal_nj;
  logic [1:0] ALUSrcB_nj, ALUOp_nj, PCSource_nj;
  logic [3:0] State_nj;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDest(RegDest), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Illegal(Illegal), .State(State)
  );

  multicycle_control #(.ENABLE_JUMP(1'b0)) u_nj (
    .clk(clk), .reset(reset), .opcode(opcode), .MemReady(MemReady),
    .PCWrite(PCWrite_nj), .PCWriteCond(PCWriteCond_nj), .IorD(IorD_nj),
    .MemRead(MemRead_nj), .MemWrite(MemWrite_nj), .IRWrite(IRWrite_nj),
    .MemToReg(MemToReg_nj), .RegDest(RegDest_nj), .RegWrite(RegWrite_nj),
    .ALUSrcA(ALUSrcA_nj), .ALUSrcB(ALUSrcB_nj), .ALUOp(ALUOp_nj),
    .PCSource(PCSource_nj), .Illegal(Illegal_nj), .State(State_nj)
  );

  wire [5:0] strobes = {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    MemReady = 1'b1;
    opcode   = 6'h00;

    // reset held two cycles
    tick();
    check("rst1_state", State, 0);
    check("rst1_strobes", strobes, 0);
    tick();
    check("rst2_state", State, 0);
    check("rst2_strobes", strobes, 0);
    reset = 1'b0;
    #1;
    check("fetch_state", State, 0);
    check("fetch_pcwrite", PCWrite, 1);
    check("fetch_irwrite", IRWrite, 1);
    check("fetch_memread", MemRead, 1);
    check("fetch_alusrcb", ALUSrcB, 2'b01);

    // lw: 0,1,2,3,4,0 ; opcode changes after DECODE are ignored
    opcode = 6'h23;
    tick(); check("lw_s1", State, 1);
    check("lw_s1_alusrcb", ALUSrcB, 2'b11);
    tick(); check("lw_s2", State, 2);
    check("lw_s2_alusrcb", ALUSrcB, 2'b10);
    opcode = 6'h2B;
    tick(); check("lw_s3", State, 3);
    check("lw_s3_memread", MemRead, 1);
    check("lw_s3_iord", IorD, 1);
    check("lw_s3_regwrite", RegWrite, 0);
    tick(); check("lw_s4", State, 4);
    check("lw_s4_regwrite", RegWrite, 1);
    check("lw_s4_memtoreg", MemToReg, 1);
    tick(); check("lw_s0", State, 0);
    check("lw_s0_regwrite", RegWrite, 0);

    // sw with three stall cycles in MEMWR
    tick(); check("sw_s1", State, 1);
    tick(); check("sw_s2", State, 2);
    tick(); MemReady = 1'b0; #1;
    check("sw_hold0", State, 5);
    check("sw_hold0_memwrite", MemWrite, 1);
    check("sw_hold0_regwrite", RegWrite, 0);
    tick(); check("sw_hold1", State, 5);
    check("sw_hold1_memwrite", MemWrite, 1);
    tick(); check("sw_hold2", State, 5);
    check("sw_hold2_memwrite", MemWrite, 1);
    MemReady = 1'b1; #1;
    check("sw_hold3", State, 5);
    check("sw_hold3_memwrite", MemWrite, 1);
    tick(); check("sw_s0", State, 0);
    check("sw_s0_regwrite", RegWrite, 0);

    // FETCH stalls while memory is not ready
    MemReady = 1'b0; #1;
    check("fstall_pcwrite", PCWrite, 0);
    check("fstall_irwrite", IRWrite, 0);
    tick(); check("fstall_state", State, 0);
    MemReady = 1'b1;

    // R-format: 0,1,6,7,0
    opcode = 6'h00;
    tick(); check("r_s1", State, 1);
    tick(); check("r_s6", State, 6);
    check("r_s6_aluop", ALUOp, 2'b10);
    check("r_s6_alusrca", ALUSrcA, 1);
    check("r_s6_alusrcb", ALUSrcB, 2'b00);
    tick(); check("r_s7", State, 7);
    check("r_s7_regdest", RegDest, 1);
    check("r_s7_regwrite", RegWrite, 1);
    tick(); check("r_s0", State, 0);

    // beq: 0,1,8,0
    opcode = 6'h04;
    tick(); check("beq_s1", State, 1);
    tick(); check("beq_s8", State, 8);
    check("beq_aluop", ALUOp, 2'b01);
    check("beq_pcwritecond", PCWriteCond, 1);
    check("beq_pcsource", PCSource, 2'b01);
    check("beq_pcwrite", PCWrite, 0);
    tick(); check("beq_s0", State, 0);

    // addi: 0,1,10,11,0
    opcode = 6'h08;
    tick(); check("addi_s1", State, 1);
    tick(); check("addi_s10", State, 10);
    check("addi_alusrcb", ALUSrcB, 2'b10);
    tick(); check("addi_s11", State, 11);
    check("addi_regwrite", RegWrite, 1);
    check("addi_regdest", RegDest, 0);
    check("addi_memtoreg", MemToReg, 0);
    tick(); check("addi_s0", State, 0);

    // undefined opcode: 0,1,0 with a single Illegal pulse
    opcode = 6'h3F;
    tick(); check("ill_s1", State, 1);
    check("ill_s1_flag", Illegal, 0);
    tick(); check("ill_s0", State, 0);
    check("ill_s0_flag", Illegal, 1);
    opcode = 6'h02;
    tick(); check("ill_after_state", State, 1);
    check("ill_after_flag", Illegal, 0);
    check("nj_sync_state", State_nj, 1);

    // j: main instance jumps, ENABLE_JUMP=0 instance flags illegal
    tick(); check("j_s9", State, 9);
    check("j_pcwrite", PCWrite, 1);
    check("j_pcsource", PCSource, 2'b10);
    check("nj_state0", State_nj, 0);
    check("nj_illegal", Illegal_nj, 1);
    tick(); check("j_s0", State, 0);
    check("nj_illegal_clr", Illegal_nj, 0);
    check("nj_state1", State_nj, 1);

    // resync both instances, then reset in the middle of a load
    reset = 1'b1;
    tick();
    reset = 1'b0;
    opcode = 6'h23;
    tick(); check("rmid_s1", State, 1);
    tick(); check("rmid_s2", State, 2);
    tick(); check("rmid_s3", State, 3);
    check("rmid_s3_memread", MemRead, 1);
    reset = 1'b1; #1;
    check("rmid_rst_memread", MemRead, 0);
    check("rmid_rst_regwrite", RegWrite, 0);
    check("rmid_rst_strobes", strobes, 0);
    tick(); check("rmid_state0", State, 0);
    reset = 1'b0;
    tick(); check("rmid_no_memwb", State, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
